// File: rtl/gce_seq.sv
// Clock-enable sequencer for a bank of gated clock domains sharing clki.
// Grants CE changes one domain at a time, round-robin, spaced by a stagger timer.
//
// state  | meaning
// S_IDLE | free to grant the next pending CE change
// S_WAIT | stagger timer running, no CE change allowed
module gce_seq #(
   parameter int N       = 4,
   parameter int STAGGER = 4,
   parameter int MIN_ON  = 8,
   parameter int ACK_DLY = 2
) (
   input  logic         clki,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] ce,
   output logic [N-1:0] ack,
   output logic         busy
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
   localparam int OW = $clog2(MIN_ON + 1);
   localparam int AW = $clog2(ACK_DLY + 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t         state, state_nxt;
   logic [N-1:0]   rreq;
   logic [N-1:0]   pend;
   logic [N-1:0]   ce_nxt;
   logic [PW-1:0]  ptr, ptr_nxt;
   logic [SW-1:0]  stg_cnt, stg_nxt;
   logic [PW-1:0]  sel;
   logic           found;
   logic [OW-1:0]  on_cnt  [N];
   logic [AW-1:0]  ack_cnt [N];

   // An off change only becomes pending once the minimum on-time has saturated.
   always_comb begin
      pend = '0;
      for (int i = 0; i < N; i++) begin
         pend[i] = (rreq[i] & ~ce[i]) |
                   (~rreq[i] & ce[i] & (on_cnt[i] == OW'(MIN_ON)));
      end
   end

   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int j = 0; j < N; j++) begin
         if (!found && pend[(int'(ptr) + j) % N]) begin
            found = 1'b1;
            sel   = PW'((int'(ptr) + j) % N);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ce_nxt    = ce;
      ptr_nxt   = ptr;
      stg_nxt   = stg_cnt;
      case (state)
         S_IDLE: begin
            if (found) begin
               ce_nxt[sel] = ~ce[sel];
               ptr_nxt     = PW'((int'(sel) + 1) % N);
               stg_nxt     = SW'(STAGGER - 1);
               state_nxt   = S_WAIT;
            end
         end
         S_WAIT: begin
            // Leaving on the edge where the count reaches zero keeps grants STAGGER edges apart.
            if (stg_cnt <= SW'(1)) begin
               stg_nxt   = '0;
               state_nxt = S_IDLE;
            end else begin
               stg_nxt = stg_cnt - SW'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ce      <= '0;
         ptr     <= '0;
         stg_cnt <= '0;
         rreq    <= '0;
      end else begin
         state   <= state_nxt;
         ce      <= ce_nxt;
         ptr     <= ptr_nxt;
         stg_cnt <= stg_nxt;
         rreq    <= req;
      end
   end

   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            on_cnt[i]  <= '0;
            ack_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!ce[i]) begin
               on_cnt[i]  <= '0;
               ack_cnt[i] <= '0;
            end else begin
               if (on_cnt[i] != OW'(MIN_ON))
                  on_cnt[i] <= on_cnt[i] + OW'(1);
               if (ack_cnt[i] != AW'(ACK_DLY))
                  ack_cnt[i] <= ack_cnt[i] + AW'(1);
            end
         end
      end
   end

   // Gating with ce makes ack fall on the same edge as its CE.
   always_comb begin
      ack = '0;
      for (int i = 0; i < N; i++)
         ack[i] = ce[i] & (ack_cnt[i] == AW'(ACK_DLY));
   end

   assign busy = (state == S_WAIT) | (|pend);

endmodule
